// File: rtl/potential_decay_array.sv
// Membrane-potential array with per-neuron decay rate. A timestep (external
// pulse or internal tick) launches a one-neuron-per-cycle sweep that decays
// each potential, writes it back and streams it to the threshold stage.
module potential_decay_array #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 4,
  parameter int AUTO_STEP   = 0,
  parameter int STEP_PERIOD = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              init_valid,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic [3:0]        init_rate,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_potential,
  output logic              wr_ready,
  input  logic              step,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              done,
  output logic              step_overrun,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_potential
);

  localparam int                CNT_W = $clog2(STEP_PERIOD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_PERIOD - 1);
  localparam logic [ADDR_W:0]   NN = (ADDR_W + 1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem  [NUM_NEURONS];
  logic [3:0]        rate [NUM_NEURONS];
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              tick, step_any, init_ok, upd_ok;
  logic [31:0]       decayed;

  // Float32 decay by power-of-two or x0.75, truncating toward zero.
  function automatic logic [31:0] decay(input logic [31:0] x, input logic [3:0] r);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [24:0] sum;
    logic [7:0]  sh;
    logic [31:0] y;
    s   = x[31];
    e   = x[30:23];
    m   = x[22:0];
    sum = {1'b0, 1'b1, m} + {2'b0, 1'b1, m[22:1]};
    y   = x;
    case (r)
      4'b0010: sh = 8'd1;
      4'b0100: sh = 8'd2;
      4'b1000: sh = 8'd3;
      default: sh = 8'd0;
    endcase
    if (e == 8'hFF)        y = x;
    else if (e == 8'h00)   y = {s, 31'b0};
    else if (r == 4'b0011) begin
      if (sum[24])         y = {s, e, sum[23:1]};
      else if (e == 8'd1)  y = {s, 31'b0};
      else                 y = {s, e - 8'd1, sum[22:0]};
    end
    else if (sh != 8'd0) begin
      if (e <= sh)         y = {s, 31'b0};
      else                 y = {s, e - sh, m};
    end
    return y;
  endfunction

  assign wr_ready = ~busy;
  assign tick     = (AUTO_STEP != 0) && (cnt == CNT_LAST);
  assign step_any = step | tick;
  assign init_ok  = init_valid && wr_ready && ({1'b0, init_addr} < NN);
  assign upd_ok   = upd_valid  && wr_ready && ({1'b0, upd_addr}  < NN);
  assign decayed  = decay(mem[idx], rate[idx]);

  // Debug read port, zero for addresses beyond the array.
  always_comb begin
    rd_potential = 32'h0;
    if ({1'b0, rd_addr} < NN) rd_potential = mem[rd_addr];
  end

  // Free-running timestep counter; keeps counting through sweeps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // Register file: sweep write-back, else init (wins over upd), else upd.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i]  <= 32'h0;
        rate[i] <= 4'b0001;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (state == SWEEP && idx == ADDR_W'(i)) begin
          mem[i] <= decayed;
        end else if (init_ok && init_addr == ADDR_W'(i)) begin
          mem[i]  <= init_potential;
          rate[i] <= init_rate;
        end else if (upd_ok && upd_addr == ADDR_W'(i)) begin
          mem[i] <= upd_potential;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_any) state_nxt = SWEEP;
      SWEEP:   if (idx == IDX_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep datapath: index, output stream, done pulse and overrun flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy          <= 1'b0;
      idx           <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_potential <= 32'h0;
      done          <= 1'b0;
      step_overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (step_any && busy) step_overrun <= 1'b1;
      case (state)
        IDLE: if (step_any) begin
          busy <= 1'b1;
          idx  <= '0;
        end
        SWEEP: begin
          out_valid     <= 1'b1;
          out_addr      <= idx;
          out_potential <= decayed;
          idx           <= idx + 1'b1;
        end
        DONE: begin
          out_valid <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
